// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate datapath: product width,
// accumulator FSM states and accumulator sizing helper.
package mac_pkg;

  localparam int MAC_PROD_W = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

  // Smallest accumulator width that can never carry out over a full frame.
  function automatic int min_acc_w(input int count, input int prod_w);
    return prod_w + $clog2(count);
  endfunction

endpackage

// File: rtl/product_accumulator.sv
// Sums a fixed-length frame of COUNT unsigned products and presents the total
// with a sticky carry-out flag on a valid/ready result port.
module product_accumulator
  import mac_pkg::*;
#(
  parameter int PROD_W = MAC_PROD_W,
  parameter int ACC_W  = 12,
  parameter int COUNT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int CNT_W = $clog2(COUNT);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(COUNT - 1);

  generate
    if (ACC_W < PROD_W) begin : g_bad_acc_w
      $error("product_accumulator: ACC_W must be at least PROD_W");
    end
    if (COUNT < 2) begin : g_bad_count
      $error("product_accumulator: COUNT must be at least 2");
    end
    if (ACC_W < min_acc_w(COUNT, PROD_W)) begin : g_narrow_acc
      $warning("product_accumulator: ACC_W narrower than frame worst case, out_ovf may assert");
    end
  endgenerate

  acc_state_t       state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             ovf_reg, ovf_next;
  logic [ACC_W-1:0] sum_reg, sum_next;
  logic             sum_ovf_reg, sum_ovf_next;

  logic [ACC_W:0]   add_full;
  logic [ACC_W-1:0] acc_beat;
  logic             ovf_beat;

  // First beat of a frame loads rather than adds, so no explicit acc clear is needed.
  always_comb begin
    add_full = {1'b0, acc_reg} + (ACC_W + 1)'(in_prod);
    if (cnt_reg == '0) begin
      acc_beat = ACC_W'(in_prod);
      ovf_beat = 1'b0;
    end else begin
      acc_beat = add_full[ACC_W-1:0];
      ovf_beat = ovf_reg | add_full[ACC_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ACCUM;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      ovf_reg     <= 1'b0;
      sum_reg     <= '0;
      sum_ovf_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
      ovf_reg     <= ovf_next;
      sum_reg     <= sum_next;
      sum_ovf_reg <= sum_ovf_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    cnt_next     = cnt_reg;
    ovf_next     = ovf_reg;
    sum_next     = sum_reg;
    sum_ovf_next = sum_ovf_reg;
    in_ready     = 1'b0;
    out_valid    = 1'b0;

    case (state_reg)
      ACCUM: in_ready  = 1'b1;
      HOLD:  out_valid = 1'b1;
      default: ;
    endcase

    // clr outranks both beat acceptance and the result handshake.
    if (clr) begin
      state_next = ACCUM;
      cnt_next   = '0;
      ovf_next   = 1'b0;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (in_valid) begin
            acc_next = acc_beat;
            ovf_next = ovf_beat;
            if (cnt_reg == LAST_BEAT) begin
              cnt_next     = '0;
              state_next   = HOLD;
              sum_next     = acc_beat;
              sum_ovf_next = ovf_beat;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_next = ACCUM;
          end
        end
        default: state_next = ACCUM;
      endcase
    end
  end

  assign out_sum = sum_reg;
  assign out_ovf = sum_ovf_reg;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator with COUNT=4, ACC_W=9 so that both
// wrapping and non-wrapping frames are exercised by one instance.
module tb_product_accumulator;

  localparam int PROD_W = 8;
  localparam int ACC_W  = 9;
  localparam int COUNT  = 4;

  logic              clk;
  logic              rst;
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_ovf;

  int checks;
  int errors;

  product_accumulator #(
    .PROD_W(PROD_W),
    .ACC_W (ACC_W),
    .COUNT (COUNT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_prod  (in_prod),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_ovf  (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [PROD_W-1:0] p);
    in_valid = 1'b1;
    in_prod  = p;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    out_ready = 1'b1;

    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_ovf", out_ovf, 0);
    step();
    step();
    rst = 1'b0;
    step();

    // Test 1: basic frame, 6+15+24+15
    send(6); send(15); send(24); send(15);
    check("t1_out_valid", out_valid, 1);
    check("t1_in_ready_hold", in_ready, 0);
    check("t1_sum", out_sum, 60);
    check("t1_ovf", out_ovf, 0);
    step();
    check("t1_in_ready_back", in_ready, 1);
    check("t1_out_valid_low", out_valid, 0);

    // Test 2: wrap mod 512 and per-frame ovf clear
    send(225); send(225); send(225); send(120);
    check("t2_sum_wrap", out_sum, 283);
    check("t2_ovf", out_ovf, 1);
    step();
    send(1); send(1); send(1); send(1);
    check("t2_sum_next", out_sum, 4);
    check("t2_ovf_cleared", out_ovf, 0);
    step();

    // Test 3: backpressure with ignored input beats
    out_ready = 1'b0;
    send(120); send(120); send(120); send(120);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_prod  = 8'd7;
      check($sformatf("t3_valid_%0d", i), out_valid, 1);
      check($sformatf("t3_sum_%0d", i), out_sum, 480);
      check($sformatf("t3_in_ready_%0d", i), in_ready, 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("t3_released", out_valid, 0);
    check("t3_in_ready", in_ready, 1);

    // Test 4: gapped input
    send(10); step(); step();
    send(20); step();
    send(30);
    check("t4_not_done", out_valid, 0);
    send(40);
    check("t4_valid", out_valid, 1);
    check("t4_sum", out_sum, 100);
    step();

    // Test 5a: clr mid-frame discards partial sum and the concurrent beat
    send(50); send(50);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_prod  = 8'd99;
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    check("t5_clr_in_ready", in_ready, 1);
    send(1); send(2); send(3);
    check("t5_not_done", out_valid, 0);
    send(4);
    check("t5_sum", out_sum, 10);
    step();

    // Test 5b: clr in HOLD wins over out_ready and drops the result
    out_ready = 1'b0;
    send(5); send(5); send(5); send(5);
    check("t5_hold_valid", out_valid, 1);
    check("t5_hold_sum", out_sum, 20);
    clr       = 1'b1;
    out_ready = 1'b1;
    step();
    clr = 1'b0;
    check("t5_dropped", out_valid, 0);
    check("t5_sum_kept", out_sum, 20);
    check("t5_in_ready", in_ready, 1);

    // Test 6: async reset mid-frame, between edges
    send(6); send(15);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_in_ready", in_ready, 1);
    check("t6_async_out_valid", out_valid, 0);
    check("t6_async_sum", out_sum, 0);
    step();
    rst = 1'b0;
    step();
    send(6); send(15); send(24); send(15);
    check("t6_valid", out_valid, 1);
    check("t6_sum", out_sum, 60);
    check("t6_ovf", out_ovf, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
